// File: rtl/midi_note_parser.sv
// MIDI byte parser: synchronizes the EXT_CLK byte strobe, decodes Note On/Off
// with running status, and drives note event pulses plus a last-note gate.
module midi_note_parser #(
    parameter bit         OMNI    = 1'b1,
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       CLK_24MHZ,
    input  logic       RST,
    input  logic       EXT_CLK,
    input  logic [7:0] data_pins_i,
    output logic       note_on_o,
    output logic       note_off_o,
    output logic [3:0] channel_o,
    output logic [6:0] note_o,
    output logic [6:0] velocity_o,
    output logic       gate_o,
    output logic [6:0] held_note_o
);

    localparam int unsigned CHAN_W = 4;
    localparam int unsigned NOTE_W = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q, edge_q;
    logic [7:0]          rs_q, rs_d;
    logic [NOTE_W-1:0]   d1_q, d1_d;
    logic                note_on_q, note_on_d;
    logic                note_off_q, note_off_d;
    logic [CHAN_W-1:0]   channel_q, channel_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [NOTE_W-1:0]   velocity_q, velocity_d;
    logic                gate_q, gate_d;
    logic [NOTE_W-1:0]   held_q, held_d;
    logic                byte_stb;
    logic                chan_ok;

    always_ff @(posedge CLK_24MHZ or posedge RST) begin
        if (RST) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            edge_q     <= 1'b0;
            state_q    <= IDLE;
            rs_q       <= 8'h00;
            d1_q       <= '0;
            note_on_q  <= 1'b0;
            note_off_q <= 1'b0;
            channel_q  <= '0;
            note_q     <= '0;
            velocity_q <= '0;
            gate_q     <= 1'b0;
            held_q     <= '0;
        end else begin
            sync1_q    <= EXT_CLK;
            sync2_q    <= sync1_q;
            edge_q     <= sync2_q;
            state_q    <= state_d;
            rs_q       <= rs_d;
            d1_q       <= d1_d;
            note_on_q  <= note_on_d;
            note_off_q <= note_off_d;
            channel_q  <= channel_d;
            note_q     <= note_d;
            velocity_q <= velocity_d;
            gate_q     <= gate_d;
            held_q     <= held_d;
        end
    end

    // Falling edge of the synchronized strobe lands mid data-valid window.
    assign byte_stb = edge_q & ~sync2_q;
    assign chan_ok  = OMNI || (rs_q[3:0] == CHANNEL);

    always_comb begin
        state_d    = state_q;
        rs_d       = rs_q;
        d1_d       = d1_q;
        note_on_d  = 1'b0;
        note_off_d = 1'b0;
        channel_d  = channel_q;
        note_d     = note_q;
        velocity_d = velocity_q;
        gate_d     = gate_q;
        held_d     = held_q;
        if (byte_stb) begin
            if (data_pins_i[7:3] == 5'b11111) begin
                state_d = state_q;
            end else if (data_pins_i[7:4] == 4'hF) begin
                rs_d    = 8'h00;
                state_d = IDLE;
            end else if (data_pins_i[7]) begin
                rs_d    = data_pins_i;
                state_d = WAIT_D1;
            end else begin
                case (state_q)
                    WAIT_D1: begin
                        // Program change / channel pressure carry a single data byte.
                        if (rs_q[7:5] != 3'b110) begin
                            d1_d    = data_pins_i[6:0];
                            state_d = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        state_d = WAIT_D1;
                        if ((rs_q[7:5] == 3'b100) && chan_ok) begin
                            channel_d  = rs_q[3:0];
                            note_d     = d1_q;
                            velocity_d = data_pins_i[6:0];
                            if (rs_q[4] && (data_pins_i[6:0] != 7'd0)) begin
                                note_on_d = 1'b1;
                                gate_d    = 1'b1;
                                held_d    = d1_q;
                            end else begin
                                note_off_d = 1'b1;
                                if (gate_q && (d1_q == held_q)) begin
                                    gate_d = 1'b0;
                                end
                            end
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    assign note_on_o   = note_on_q;
    assign note_off_o  = note_off_q;
    assign channel_o   = channel_q;
    assign note_o      = note_q;
    assign velocity_o  = velocity_q;
    assign gate_o      = gate_q;
    assign held_note_o = held_q;

endmodule

// File: tb/tb_midi_note_parser.sv
// Scoreboard bench: an omni instance and a channel-0-only instance share the
// byte stream; expected events are queued per instance and popped on pulses.
module tb_midi_note_parser;

    typedef struct packed {
        logic       on;
        logic [3:0] ch;
        logic [6:0] note;
        logic [6:0] vel;
        logic       gate;
        logic [6:0] held;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ext_clk = 1'b0;
    logic [7:0] data = 8'h00;

    logic       a_on, a_off, a_gate, b_on, b_off, b_gate;
    logic [3:0] a_ch, b_ch;
    logic [6:0] a_note, a_vel, a_held, b_note, b_vel, b_held;

    int checks = 0;
    int errors = 0;
    evt_t qa[$];
    evt_t qb[$];

    always #21 clk = ~clk;

    midi_note_parser #(.OMNI(1'b1), .CHANNEL(4'd0)) u_a (
        .CLK_24MHZ(clk), .RST(rst), .EXT_CLK(ext_clk), .data_pins_i(data),
        .note_on_o(a_on), .note_off_o(a_off), .channel_o(a_ch), .note_o(a_note),
        .velocity_o(a_vel), .gate_o(a_gate), .held_note_o(a_held)
    );

    midi_note_parser #(.OMNI(1'b0), .CHANNEL(4'd0)) u_b (
        .CLK_24MHZ(clk), .RST(rst), .EXT_CLK(ext_clk), .data_pins_i(data),
        .note_on_o(b_on), .note_off_o(b_off), .channel_o(b_ch), .note_o(b_note),
        .velocity_o(b_vel), .gate_o(b_gate), .held_note_o(b_held)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_evt(input string tag, input evt_t got, input evt_t exp);
        chk({tag, "_kind"}, 32'(got.on), 32'(exp.on));
        chk({tag, "_ch"},   32'(got.ch), 32'(exp.ch));
        chk({tag, "_note"}, 32'(got.note), 32'(exp.note));
        chk({tag, "_vel"},  32'(got.vel), 32'(exp.vel));
        chk({tag, "_gate"}, 32'(got.gate), 32'(exp.gate));
        chk({tag, "_held"}, 32'(got.held), 32'(exp.held));
    endtask

    always @(negedge clk) begin
        if (!rst && (a_on || a_off)) begin
            chk("a_excl", 32'(a_on & a_off), 32'd0);
            if (qa.size() == 0) chk("a_unexpected", 32'd1, 32'd0);
            else cmp_evt("a", {a_on, a_ch, a_note, a_vel, a_gate, a_held}, qa.pop_front());
        end
        if (!rst && (b_on || b_off)) begin
            chk("b_excl", 32'(b_on & b_off), 32'd0);
            if (qb.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
            else cmp_evt("b", {b_on, b_ch, b_note, b_vel, b_gate, b_held}, qb.pop_front());
        end
    end

    // 1 MHz byte strobe: data changes on the rising edge.
    task automatic send(input logic [7:0] b);
        data    = b;
        ext_clk = 1'b1;
        #500;
        ext_clk = 1'b0;
        #500;
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send(s[i]);
        #400;
    endtask

    task automatic push(input bit to_a, input bit to_b, input evt_t e);
        if (to_a) qa.push_back(e);
        if (to_b) qb.push_back(e);
    endtask

    task automatic drained(input string tag);
        chk({tag, "_qa_empty"}, 32'(qa.size()), 32'd0);
        chk({tag, "_qb_empty"}, 32'(qb.size()), 32'd0);
        qa.delete();
        qb.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_outs"}, 32'({a_on, a_off, a_ch, a_note, a_vel, a_gate, a_held}), 32'd0);
        chk({tag, "_b_outs"}, 32'({b_on, b_off, b_ch, b_note, b_vel, b_gate, b_held}), 32'd0);
    endtask

    initial begin
        #100;
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        #200;

        // Idle-default loop, two passes; channel 12 is filtered on instance b.
        for (int p = 0; p < 2; p++) begin
            push(1, 0, '{1'b1, 4'd12, 7'h50, 7'h7F, 1'b1, 7'h50});
            send_seq('{8'h9C, 8'h50, 8'h7F, 8'h00});
        end
        drained("idle_loop");
        chk("b_ch12_filtered", 32'({b_note, b_gate}), 32'd0);

        push(1, 1, '{1'b1, 4'd0, 7'h3C, 7'h64, 1'b1, 7'h3C});
        push(1, 1, '{1'b0, 4'd0, 7'h3C, 7'h00, 1'b0, 7'h3C});
        send_seq('{8'h90, 8'h3C, 8'h64, 8'h3C, 8'h00});
        drained("running");

        push(1, 1, '{1'b1, 4'd0, 7'h3C, 7'h64, 1'b1, 7'h3C});
        send_seq('{8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64});
        drained("realtime");

        push(1, 1, '{1'b1, 4'd0, 7'h3C, 7'h64, 1'b1, 7'h3C});
        push(1, 1, '{1'b1, 4'd0, 7'h40, 7'h64, 1'b1, 7'h40});
        push(1, 1, '{1'b0, 4'd0, 7'h3C, 7'h00, 1'b1, 7'h40});
        send_seq('{8'h90, 8'h3C, 8'h64, 8'h90, 8'h40, 8'h64, 8'h80, 8'h3C, 8'h00});
        drained("mismatch_off");
        chk("mismatch_gate", 32'({a_gate, a_held}), 32'({1'b1, 7'h40}));
        push(1, 1, '{1'b0, 4'd0, 7'h40, 7'h00, 1'b0, 7'h40});
        send_seq('{8'h80, 8'h40, 8'h00});
        drained("match_off");

        // Channel 1 note reaches only the omni instance.
        push(1, 0, '{1'b1, 4'd1, 7'h3C, 7'h64, 1'b1, 7'h3C});
        send_seq('{8'h91, 8'h3C, 8'h64});
        send_seq('{8'hC0, 8'h05, 8'h3C});
        send_seq('{8'hB0, 8'h07, 8'h64});
        send_seq('{8'h90, 8'h3C, 8'hF0, 8'h64});
        drained("filter");
        chk("b_hold_outs", 32'({b_ch, b_note, b_vel, b_gate}), 32'({4'd0, 7'h40, 7'h00, 1'b0}));
        push(1, 1, '{1'b1, 4'd0, 7'h3C, 7'h64, 1'b1, 7'h3C});
        send_seq('{8'h90, 8'h3C, 8'h64});
        drained("after_filter");

        // Reset mid-message loses the partial message and clears everything.
        send_seq('{8'h9C, 8'h50});
        rst = 1'b1;
        #200;
        @(negedge clk);
        chk_zero("mid_reset");
        rst = 1'b0;
        #200;
        send_seq('{8'h7F, 8'h45, 8'h20});
        drained("post_reset");
        chk_zero("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
